output_packer: RTL

OUTPUT_PACKER -- requirements
Module: output_packer

---
 rtl/output_packer_if.sv | 12 +
 rtl/output_packer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/output_packer_if.sv
// Output stream bundle between the output packer (master) and the output FIFO (slave).
interface output_packer_if #(
    parameter int DATA_WIDTH_FIFO_OUT = 64
);
    logic [DATA_WIDTH_FIFO_OUT-1:0] m_tdata;
    logic                           m_tvalid;
    logic                           m_tlast;
    logic                           m_tready;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/output_packer.sv
// Captures one MXU result vector, packs columns into 64-bit words by precision and streams them out.
// Macro OUTPUT_PACKER_SATURATE_EN selects signed saturation instead of truncation when narrowing columns.
module output_packer #(
    parameter int COLUMNS             = 3,
    parameter int DATA_WIDTH_FIFO_OUT = 64,
    parameter int ACC_WIDTH           = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     i_data_precision,
    input  logic                           i_ld_max_down_cnt,
    input  logic [$clog2(COLUMNS):0]       i_max_down_cnt_from_cu,
    input  logic                           i_enable_down_cnt,
    input  logic                           i_enable_store_activation_data,
    input  logic [COLUMNS*ACC_WIDTH-1:0]   i_mxu_result,
    output_packer_if.master                m_axis,
    output logic                           o_busy,
    output logic                           o_overflow
);
    localparam int CW = $clog2(COLUMNS) + 1;
    localparam int IW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int NW = 1 << IW;
    localparam int SW = ((ACC_WIDTH > 64) ? ACC_WIDTH : 64) + 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CAPTURE    = 2'd1,
        EMIT       = 2'd2,
        WAIT_READY = 2'd3
    } state_t;

    state_t                       r_state;
    state_t                       w_next_state;
    logic [COLUMNS*ACC_WIDTH-1:0] r_mxu_result;
    logic [1:0]                   r_precision;
    logic [CW-1:0]                r_down_cnt;
    logic [IW-1:0]                r_index;
    logic                         r_overflow;
    logic [63:0]                  w_packed [NW];
    logic                         w_valid;
    logic                         w_last;
    logic                         w_xfer;
    logic                         w_step;

    // Narrow one column to a lane of i_w bits; the result is zero-extended to 64 bits.
    function automatic logic [63:0] f_reduce(input logic [ACC_WIDTH-1:0] i_v, input int i_w);
        logic signed [SW-1:0] v_ext;
        logic signed [SW-1:0] v_one;
        logic signed [SW-1:0] v_mask;
        logic signed [SW-1:0] v_res;
`ifdef OUTPUT_PACKER_SATURATE_EN
        logic signed [SW-1:0] v_max;
        logic signed [SW-1:0] v_min;
`endif
        v_ext  = SW'(signed'(i_v));
        v_one  = SW'(1);
        v_mask = (v_one <<< i_w) - v_one;
`ifdef OUTPUT_PACKER_SATURATE_EN
        v_max = (v_one <<< (i_w - 1)) - v_one;
        v_min = -(v_one <<< (i_w - 1));
        if (v_ext > v_max) begin
            v_res = v_max;
        end else if (v_ext < v_min) begin
            v_res = v_min;
        end else begin
            v_res = v_ext;
        end
`else
        v_res = v_ext;
`endif
        return 64'(v_res & v_mask);
    endfunction

    always_comb begin
        for (int w = 0; w < NW; w++) begin
            w_packed[w] = '0;
        end
        for (int c = 0; c < COLUMNS; c++) begin
            case (r_precision)
                2'b00:   w_packed[IW'(c / 8)][(c % 8) * 8 +: 8] =
                             8'(f_reduce(r_mxu_result[c*ACC_WIDTH +: ACC_WIDTH], 8));
                2'b01:   w_packed[IW'(c / 4)][(c % 4) * 16 +: 16] =
                             16'(f_reduce(r_mxu_result[c*ACC_WIDTH +: ACC_WIDTH], 16));
                2'b10:   w_packed[IW'(c / 2)][(c % 2) * 32 +: 32] =
                             32'(f_reduce(r_mxu_result[c*ACC_WIDTH +: ACC_WIDTH], 32));
                default: w_packed[IW'(c)] = f_reduce(r_mxu_result[c*ACC_WIDTH +: ACC_WIDTH], 64);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_valid      = (r_state == EMIT) || (r_state == WAIT_READY);
        w_last       = w_valid && (r_down_cnt == '0);
        w_xfer       = w_valid && m_axis.m_tready;
        w_step       = w_xfer && i_enable_down_cnt;
        case (r_state)
            IDLE:    if (i_enable_store_activation_data) w_next_state = CAPTURE;
            CAPTURE: w_next_state = EMIT;
            EMIT, WAIT_READY: begin
                if (w_xfer) begin
                    w_next_state = w_last ? IDLE : EMIT;
                end else begin
                    w_next_state = WAIT_READY;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Counter and index move only on an enabled transfer, so a stalled or frozen word is re-presented as-is.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mxu_result <= '0;
            r_precision  <= '0;
            r_down_cnt   <= '0;
            r_index      <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (r_state == IDLE && i_enable_store_activation_data) begin
                r_mxu_result <= i_mxu_result;
                r_precision  <= i_data_precision;
            end
            if (r_state != IDLE && i_enable_store_activation_data) begin
                r_overflow <= 1'b1;
            end
            if (i_ld_max_down_cnt) begin
                r_down_cnt <= i_max_down_cnt_from_cu;
            end else if (w_step && r_down_cnt != '0) begin
                r_down_cnt <= r_down_cnt - 1'b1;
            end
            if (r_state == CAPTURE) begin
                r_index <= '0;
            end else if (w_step && r_index != IW'(COLUMNS - 1)) begin
                r_index <= r_index + 1'b1;
            end
        end
    end

    assign m_axis.m_tvalid = w_valid;
    assign m_axis.m_tlast  = w_last;
    assign m_axis.m_tdata  = w_valid ? DATA_WIDTH_FIFO_OUT'(w_packed[r_index]) : '0;
    assign o_busy          = (r_state != IDLE);
    assign o_overflow      = r_overflow;

endmodule
